tex_bilerp_unit: RTL and testbench
==================================

Name: tex_bilerp_unit

Overview:
- Texture sampler stage directly downstream of the texture memory stage.
- Consumes the four fetched texels per lane: (u0,v0), (u1,v0), (u0,v1), (u1,v1).
- Unpacks them to RGBA8 and applies point or bilinear filtering with 8-bit fractional weights.
- Returns one packed RGBA8 color per lane to the texture unit response path, through a 3-stage stallable pipeline.

Parameters:
- CORE_ID, 0, core index used for debug/trace only
- REQ_INFOW, 1, width of opaque tag carried alongside each request
- NUM_REQS, 1, number of lanes processed in parallel

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  input request valid
- req_tmask  in  NUM_REQS  active-lane mask
- req_filter  in  TEX_FILTER_BITS(1)  0 = point, 1 = bilinear
- req_format  in  TEX_FORMAT_BITS(2)  texel format, uniform across lanes
- req_blend_u  in  NUM_REQS×8  horizontal fraction per lane
- req_blend_v  in  NUM_REQS×8  vertical fraction per lane
- req_data  in  NUM_REQS×4×32  raw texels; index 0..3 = (u0,v0),(u1,v0),(u0,v1),(u1,v1)
- req_info  in  REQ_INFOW  opaque tag
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  response valid
- rsp_tmask  out  NUM_REQS  lane mask of the response
- rsp_data  out  NUM_REQS×32  RGBA8 color; [7:0]=R, [15:8]=G, [23:16]=B, [31:24]=A
- rsp_info  out  REQ_INFOW  tag of the response
- rsp_ready  in  1  downstream accepts response

Behaviour:
- Reset: all stage valid bits 0; all pipeline registers 0; rsp_valid/rsp_tmask/rsp_data/rsp_info = 0. req_ready = 1 once out of reset.
- Reset asserted mid-operation discards all in-flight requests; no response is produced for them.
- Pipeline:
  - S0 unpacks each texel to RGBA8.
  - S1 does two horizontal lerps per channel: row v0 = lerp(t0,t1,fu); row v1 = lerp(t2,t3,fu).
  - S2 does the vertical lerp(row0,row1,fv) and packs the result.
  - Latency is exactly 3 cycles from acceptance to rsp_valid when not stalled.
  - Throughput is 1 request per cycle.
- Stall: stall = rsp_valid && !rsp_ready.
  - When stalled, every stage holds its contents and req_ready = 0.
  - Otherwise all stages advance and req_ready = 1.
  - Bubbles are not squashed. Order is preserved.
  - While stalled, rsp_* hold stable until accepted.
- Lerp arithmetic: lerp(a,b,f) = (a*(256-f) + b*f + 128) >> 8, with a 17-bit intermediate and the result truncated to 8 bits. f = 0 returns a exactly; f = 0xFF with a=0, b=0xFF returns 0xFE.
- Point filter: output = unpacked t0; fractions and t1..t3 are ignored. Latency is unchanged.
- Formats (low bits of each 32-bit word are used):
  - 0 RGBA8: word as-is.
  - 1 R5G6B5: [4:0]=B, [10:5]=G, [15:11]=R; expansion by MSB replication ({r5,r5[4:2]}, {g6,g6[5:4]}); A=0xFF.
  - 2 RGBA4: [3:0]=R, [7:4]=G, [11:8]=B, [15:12]=A; each nibble replicated ({n,n}).
  - 3 L8: R=G=B=[7:0], A=0xFF.
- Inactive lanes (tmask bit 0) produce rsp_data lane = 0. Input data for those lanes is don't-care.
- A req_tmask of all zeros is still a valid transaction: it flows through and returns with zero data and tmask 0.

Optional Feature:
- Macro: TEX_BILERP_PERF_EN.
- Defined: adds output ports perf_req_count[31:0] (accepted requests) and perf_stall_count[31:0] (cycles with stall=1). Both counters reset to 0, wrap modulo 2^32, and update on the same edge as the event.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package tex_bilerp_pkg holds:
  - TEX_FILTER_BITS=1, TEX_FORMAT_BITS=2, TEX_BLEND_BITS=8.
  - Format encodings TEX_FORMAT_RGBA8/R5G6B5/RGBA4/L8.
  - The rgba8_t struct {r,g,b,a}.
- One natural sub-module: tex_lerp8, a combinational 8-bit single-channel lerp (a, b, f -> out), instantiated 2×4 per lane in S1 and 4 per lane in S2.

Test Plan:
- Bilinear, RGBA8, NUM_REQS=1, texels 0x00000000,0xFFFFFFFF,0x00000000,0xFFFFFFFF, fu=0x80, fv=0x00 -> rsp_data 0x80808080, exactly 3 cycles after acceptance.
- Point, R5G6B5, t0=0x0000F800 -> 0xFF0000FF; t0=0x000007E0 -> 0xFF00FF00; fractions set to random values have no effect.
- Point, L8, t0=0x0000005A -> 0xFF5A5A5A. Point, RGBA4, t0=0x0000F00F -> 0xFF0000FF.
- Boundary fractions, bilinear RGBA8, t0=0x10203040, other texels 0xFFFFFFFF: fu=fv=0 -> 0x10203040; fu=fv=0xFF on all-zero t0..t2 with t3=0xFFFFFFFF -> per-channel (lerp(0, lerp(0,0xFF,0xFF)=0xFE, 0xFF)) = 0xFD, i.e. 0xFDFDFDFD.
- Backpressure: issue 4 back-to-back requests tagged 1..4, hold rsp_ready=0 for 5 cycles once rsp_valid rises -> req_ready=0 during the stall, rsp held stable, tags 1..4 delivered in order with no loss or duplication; perf_stall_count=5 when TEX_BILERP_PERF_EN is defined.
- NUM_REQS=4, tmask=4'b0101, and async reset pulsed while 2 requests are in flight: lanes 1 and 3 return 0; after reset, rsp_valid=0 immediately and no stale responses appear.

Source files
------------

// File: rtl/tex_bilerp_pkg.sv
// Shared widths, texel format encodings, the RGBA8 color type and the texel unpack helper.
package tex_bilerp_pkg;

    localparam int TEX_FILTER_BITS = 1;
    localparam int TEX_FORMAT_BITS = 2;
    localparam int TEX_BLEND_BITS  = 8;

    localparam logic [TEX_FILTER_BITS-1:0] TEX_FILTER_POINT    = 1'b0;
    localparam logic [TEX_FILTER_BITS-1:0] TEX_FILTER_BILINEAR = 1'b1;

    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_RGBA8  = 2'd0;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_R5G6B5 = 2'd1;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_RGBA4  = 2'd2;
    localparam logic [TEX_FORMAT_BITS-1:0] TEX_FORMAT_L8     = 2'd3;

    // Declared MSB-first so the packed word has R in [7:0] and A in [31:24].
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgba8_t;

    function automatic rgba8_t tex_unpack(input logic [TEX_FORMAT_BITS-1:0] fmt,
                                          input logic [31:0] w);
        rgba8_t c;
        case (fmt)
            TEX_FORMAT_R5G6B5: begin
                c.r = {w[15:11], w[15:13]};
                c.g = {w[10:5], w[10:9]};
                c.b = {w[4:0], w[4:2]};
                c.a = 8'hFF;
            end
            TEX_FORMAT_RGBA4: begin
                c.r = {w[3:0], w[3:0]};
                c.g = {w[7:4], w[7:4]};
                c.b = {w[11:8], w[11:8]};
                c.a = {w[15:12], w[15:12]};
            end
            TEX_FORMAT_L8: begin
                c.r = w[7:0];
                c.g = w[7:0];
                c.b = w[7:0];
                c.a = 8'hFF;
            end
            TEX_FORMAT_RGBA8: c = w;
            default:          c = w;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tex_bilerp_unit_if.sv
// Request/response bundle between the texture memory stage, the bilerp unit and the response path.
interface tex_bilerp_unit_if
    import tex_bilerp_pkg::*;
#(
    parameter int NUM_REQS  = 1,
    parameter int REQ_INFOW = 1
);
    logic                               req_valid;
    logic [NUM_REQS-1:0]                req_tmask;
    logic [TEX_FILTER_BITS-1:0]         req_filter;
    logic [TEX_FORMAT_BITS-1:0]         req_format;
    logic [NUM_REQS*TEX_BLEND_BITS-1:0] req_blend_u;
    logic [NUM_REQS*TEX_BLEND_BITS-1:0] req_blend_v;
    logic [NUM_REQS*4*32-1:0]           req_data;
    logic [REQ_INFOW-1:0]               req_info;
    logic                               req_ready;

    logic                               rsp_valid;
    logic [NUM_REQS-1:0]                rsp_tmask;
    logic [NUM_REQS*32-1:0]             rsp_data;
    logic [REQ_INFOW-1:0]               rsp_info;
    logic                               rsp_ready;

    modport master (
        output req_valid, req_tmask, req_filter, req_format, req_blend_u, req_blend_v,
               req_data, req_info, rsp_ready,
        input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_info
    );

    modport slave (
        input  req_valid, req_tmask, req_filter, req_format, req_blend_u, req_blend_v,
               req_data, req_info, rsp_ready,
        output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_info
    );
endinterface

// File: rtl/tex_lerp8.sv
// Combinational 8-bit single-channel lerp: (a*(256-f) + b*f + 128) >> 8.
module tex_lerp8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:0] f_i,
    output logic [7:0] out_o
);
    logic [16:0] sum;

    assign sum   = {9'd0, a_i} * (17'd256 - {9'd0, f_i}) + {9'd0, b_i} * {9'd0, f_i} + 17'd128;
    assign out_o = 8'(sum >> 8);
endmodule

// File: rtl/tex_bilerp_unit.sv
// Unpack + point/bilinear filter, 3-cycle pipeline, whole pipe freezes while rsp is held (req_ready low).
// Optional perf counters behind TEX_BILERP_PERF_EN.
module tex_bilerp_unit
    import tex_bilerp_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int REQ_INFOW = 1,
    parameter int NUM_REQS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    tex_bilerp_unit_if.slave  tex_if
`ifdef TEX_BILERP_PERF_EN
    ,
    output logic [31:0]       perf_req_count,
    output logic [31:0]       perf_stall_count
`endif
);
    logic                           stall;
    logic                           s0_vld_q, s1_vld_q, s2_vld_q;
    logic [NUM_REQS-1:0]            s0_tmask_q, s1_tmask_q, s2_tmask_q;
    logic [REQ_INFOW-1:0]           s0_info_q, s1_info_q, s2_info_q;
    logic [NUM_REQS-1:0][7:0]       s0_fu_d, s0_fv_d, s0_fu_q, s0_fv_q, s1_fv_q;
    logic [NUM_REQS-1:0][3:0][31:0] s0_tex_d, s0_tex_q;
    logic [NUM_REQS-1:0][31:0]      row0_w, row1_w, s1_row0_q, s1_row1_q;
    logic [NUM_REQS-1:0][31:0]      vert_w, s2_data_d, s2_data_q;

    assign stall            = s2_vld_q && !tex_if.rsp_ready;
    assign tex_if.req_ready = !stall;

    // Point filtering zeroes both weights, so each lerp returns its 'a' input (t0) exactly.
    always_comb begin
        s0_tex_d = '0;
        s0_fu_d  = '0;
        s0_fv_d  = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            for (int k = 0; k < 4; k++) begin
                s0_tex_d[l][k] = tex_unpack(tex_if.req_format, tex_if.req_data[(l*4+k)*32 +: 32]);
            end
            if (tex_if.req_filter == TEX_FILTER_BILINEAR) begin
                s0_fu_d[l] = tex_if.req_blend_u[l*TEX_BLEND_BITS +: TEX_BLEND_BITS];
                s0_fv_d[l] = tex_if.req_blend_v[l*TEX_BLEND_BITS +: TEX_BLEND_BITS];
            end
        end
    end

    for (genvar l = 0; l < NUM_REQS; l++) begin : g_lane
        for (genvar c = 0; c < 4; c++) begin : g_ch
            tex_lerp8 u_row0 (
                .a_i   (s0_tex_q[l][0][c*8 +: 8]),
                .b_i   (s0_tex_q[l][1][c*8 +: 8]),
                .f_i   (s0_fu_q[l]),
                .out_o (row0_w[l][c*8 +: 8])
            );
            tex_lerp8 u_row1 (
                .a_i   (s0_tex_q[l][2][c*8 +: 8]),
                .b_i   (s0_tex_q[l][3][c*8 +: 8]),
                .f_i   (s0_fu_q[l]),
                .out_o (row1_w[l][c*8 +: 8])
            );
            tex_lerp8 u_vert (
                .a_i   (s1_row0_q[l][c*8 +: 8]),
                .b_i   (s1_row1_q[l][c*8 +: 8]),
                .f_i   (s1_fv_q[l]),
                .out_o (vert_w[l][c*8 +: 8])
            );
        end
    end

    always_comb begin
        s2_data_d = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            if (s1_tmask_q[l]) s2_data_d[l] = vert_w[l];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_vld_q   <= 1'b0;
            s0_tmask_q <= '0;
            s0_info_q  <= '0;
            s0_fu_q    <= '0;
            s0_fv_q    <= '0;
            s0_tex_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_tmask_q <= '0;
            s1_info_q  <= '0;
            s1_fv_q    <= '0;
            s1_row0_q  <= '0;
            s1_row1_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_tmask_q <= '0;
            s2_info_q  <= '0;
            s2_data_q  <= '0;
        end else if (!stall) begin
            s0_vld_q   <= tex_if.req_valid;
            s0_tmask_q <= tex_if.req_tmask;
            s0_info_q  <= tex_if.req_info;
            s0_fu_q    <= s0_fu_d;
            s0_fv_q    <= s0_fv_d;
            s0_tex_q   <= s0_tex_d;
            s1_vld_q   <= s0_vld_q;
            s1_tmask_q <= s0_tmask_q;
            s1_info_q  <= s0_info_q;
            s1_fv_q    <= s0_fv_q;
            s1_row0_q  <= row0_w;
            s1_row1_q  <= row1_w;
            s2_vld_q   <= s1_vld_q;
            s2_tmask_q <= s1_tmask_q;
            s2_info_q  <= s1_info_q;
            s2_data_q  <= s2_data_d;
        end
    end

    assign tex_if.rsp_valid = s2_vld_q;
    assign tex_if.rsp_tmask = s2_tmask_q;
    assign tex_if.rsp_info  = s2_info_q;
    assign tex_if.rsp_data  = s2_data_q;

`ifdef TEX_BILERP_PERF_EN
    logic [31:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (tex_if.req_valid && !stall) perf_req_q <= perf_req_q + 32'd1;
            if (stall) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_req_count   = perf_req_q;
    assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_tex_bilerp_unit.sv
// Directed bench for tex_bilerp_unit: 4 lanes, hand-computed colors, stall/order and async reset.
module tb_tex_bilerp_unit;
    import tex_bilerp_pkg::*;

    localparam int NR = 4;
    localparam int IW = 4;
    localparam logic [383:0] PAD = {12{32'hA5A55A5A}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_acc    = 0;

    tex_bilerp_unit_if #(.NUM_REQS(NR), .REQ_INFOW(IW)) bus ();

`ifdef TEX_BILERP_PERF_EN
    logic [31:0] perf_req, perf_stall;
`endif

    tex_bilerp_unit #(.CORE_ID(0), .REQ_INFOW(IW), .NUM_REQS(NR)) dut (
        .clk              (clk),
        .reset            (reset),
        .tex_if           (bus)
`ifdef TEX_BILERP_PERF_EN
        ,
        .perf_req_count   (perf_req),
        .perf_stall_count (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Starts #1 after a posedge with rsp_ready high; returns the first response and its latency.
    task automatic run_one(input logic [0:0] fl, input logic [1:0] fmt, input logic [3:0] tm,
                           input logic [31:0] bu, input logic [31:0] bv, input logic [511:0] dat,
                           input logic [3:0] info, output logic [127:0] rd, output logic [3:0] rtm,
                           output logic [3:0] rinfo, output int lat);
        bus.req_filter  = fl;
        bus.req_format  = fmt;
        bus.req_tmask   = tm;
        bus.req_blend_u = bu;
        bus.req_blend_v = bv;
        bus.req_data    = dat;
        bus.req_info    = info;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        n_acc++;
        bus.req_valid = 1'b0;
        bus.req_data  = {16{32'h5A5AA5A5}};
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd    = bus.rsp_data;
        rtm   = bus.rsp_tmask;
        rinfo = bus.rsp_info;
    endtask

    task automatic expect_one(input string tag, input logic [0:0] fl, input logic [1:0] fmt,
                              input logic [3:0] tm, input logic [31:0] bu, input logic [31:0] bv,
                              input logic [511:0] dat, input logic [3:0] info,
                              input logic [127:0] exp_d, input logic [3:0] exp_tm);
        logic [127:0] rd;
        logic [3:0]   rtm, rinfo;
        int           lat;
        run_one(fl, fmt, tm, bu, bv, dat, info, rd, rtm, rinfo, lat);
        check_val({tag, "_lat"}, 128'(lat), 128'd3);
        check_val({tag, "_data"}, rd, exp_d);
        check_val({tag, "_tmask"}, 128'(rtm), 128'(exp_tm));
        check_val({tag, "_info"}, 128'(rinfo), 128'(info));
    endtask

    initial begin
        logic        acc;
        int          sent, got, stall_cyc, cyc, stale;
        logic [31:0] w;

        bus.req_valid   = 1'b0;
        bus.req_tmask   = '0;
        bus.req_filter  = '0;
        bus.req_format  = '0;
        bus.req_blend_u = '0;
        bus.req_blend_v = '0;
        bus.req_data    = '0;
        bus.req_info    = '0;
        bus.rsp_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        check_val("rst_rsp_tmask", 128'(bus.rsp_tmask), 128'd0);
        check_val("rst_rsp_data", bus.rsp_data, 128'd0);
        check_val("rst_rsp_info", 128'(bus.rsp_info), 128'd0);
        check_val("rst_req_ready", 128'(bus.req_ready), 128'd1);
`ifdef TEX_BILERP_PERF_EN
        check_val("rst_perf_req", 128'(perf_req), 128'd0);
        check_val("rst_perf_stall", 128'(perf_stall), 128'd0);
`endif

        expect_one("bil_half", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0001, 32'h0000_0080, 32'h0,
                   {PAD, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 4'd1,
                   {96'h0, 32'h80808080}, 4'b0001);
        expect_one("pt_565_r", TEX_FILTER_POINT, TEX_FORMAT_R5G6B5, 4'b0001, $urandom, $urandom,
                   {PAD, $urandom, $urandom, $urandom, 32'h0000F800}, 4'd2,
                   {96'h0, 32'hFF0000FF}, 4'b0001);
        expect_one("pt_565_g", TEX_FILTER_POINT, TEX_FORMAT_R5G6B5, 4'b0001, $urandom, $urandom,
                   {PAD, $urandom, $urandom, $urandom, 32'h000007E0}, 4'd3,
                   {96'h0, 32'hFF00FF00}, 4'b0001);
        expect_one("pt_l8", TEX_FILTER_POINT, TEX_FORMAT_L8, 4'b0001, $urandom, $urandom,
                   {PAD, $urandom, $urandom, $urandom, 32'h0000005A}, 4'd4,
                   {96'h0, 32'hFF5A5A5A}, 4'b0001);
        expect_one("pt_rgba4", TEX_FILTER_POINT, TEX_FORMAT_RGBA4, 4'b0001, $urandom, $urandom,
                   {PAD, $urandom, $urandom, $urandom, 32'h0000F00F}, 4'd5,
                   {96'h0, 32'hFF0000FF}, 4'b0001);
        expect_one("bil_f00", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0001, 32'h0, 32'h0,
                   {PAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10203040}, 4'd6,
                   {96'h0, 32'h10203040}, 4'b0001);
        expect_one("bil_fff", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0001, 32'h0000_00FF, 32'h0000_00FF,
                   {PAD, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 4'd7,
                   {96'h0, 32'hFDFDFDFD}, 4'b0001);
        expect_one("lanes_0101", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0101, 32'h7740_9980, 32'h1200_3400,
                   {4{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}}, 4'd8,
                   128'h00000000_40404040_00000000_80808080, 4'b0101);
        expect_one("tmask_zero", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0000, 32'h8080_8080, 32'h0,
                   {4{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}}, 4'd9,
                   128'h0, 4'b0000);

        // Backpressure: tags 1..4 back to back, rsp_ready held low for 5 stall cycles.
        @(posedge clk);
        #1;
        sent = 0; got = 0; stall_cyc = 0; cyc = 0;
        bus.rsp_ready   = 1'b0;
        bus.req_filter  = TEX_FILTER_POINT;
        bus.req_format  = TEX_FORMAT_RGBA8;
        bus.req_tmask   = 4'b0001;
        bus.req_info    = 4'd1;
        bus.req_data    = {PAD, 96'h0, 32'h11111111};
        bus.req_valid   = 1'b1;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) begin
                    w = 32'h11111111 * 32'(got + 1);
                    check_val("bp_tag", 128'(bus.rsp_info), 128'(got + 1));
                    check_val("bp_data", bus.rsp_data, {96'h0, w});
                    got++;
                end else begin
                    stall_cyc++;
                    check_val("bp_req_ready", 128'(bus.req_ready), 128'd0);
                    check_val("bp_hold_info", 128'(bus.rsp_info), 128'd1);
                    check_val("bp_hold_data", bus.rsp_data, {96'h0, 32'h11111111});
                end
            end
            acc = bus.req_valid && bus.req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                n_acc++;
                if (sent < 4) begin
                    w = 32'h11111111 * 32'(sent + 1);
                    bus.req_info = 4'(sent + 1);
                    bus.req_data = {PAD, 96'h0, w};
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (stall_cyc >= 5) bus.rsp_ready = 1'b1;
            cyc++;
        end
        check_val("bp_got", 128'(got), 128'd4);
        check_val("bp_sent", 128'(sent), 128'd4);
        check_val("bp_stall_cycles", 128'(stall_cyc), 128'd5);
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_no_dup", 128'(bus.rsp_valid), 128'd0);
`ifdef TEX_BILERP_PERF_EN
        check_val("perf_stall", 128'(perf_stall), 128'd5);
        check_val("perf_req", 128'(perf_req), 128'(n_acc));
`endif

        // Async reset with two requests in flight, the older one already on rsp.
        bus.rsp_ready  = 1'b1;
        bus.req_filter = TEX_FILTER_POINT;
        bus.req_format = TEX_FORMAT_L8;
        bus.req_tmask  = 4'b0101;
        bus.req_data   = {4{96'h0, 32'h0000005A}};
        bus.req_info   = 4'd10;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_info = 4'd11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_pre_valid", 128'(bus.rsp_valid), 128'd1);
        check_val("rst_pre_data", bus.rsp_data, 128'h00000000_FF5A5A5A_00000000_FF5A5A5A);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_valid", 128'(bus.rsp_valid), 128'd0);
        check_val("arst_data", bus.rsp_data, 128'd0);
        check_val("arst_info", 128'(bus.rsp_info), 128'd0);
        check_val("arst_tmask", 128'(bus.rsp_tmask), 128'd0);
`ifdef TEX_BILERP_PERF_EN
        check_val("arst_perf_req", 128'(perf_req), 128'd0);
        check_val("arst_perf_stall", 128'(perf_stall), 128'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) stale++;
        end
        check_val("arst_no_stale", 128'(stale), 128'd0);
        check_val("arst_req_ready", 128'(bus.req_ready), 128'd1);

        expect_one("post_rst", TEX_FILTER_BILINEAR, TEX_FORMAT_RGBA8, 4'b0001, 32'h0000_0080, 32'h0,
                   {PAD, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 4'd12,
                   {96'h0, 32'h80808080}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
